// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives a rotating one-hot column, debounces a single
// pressed key and reports it once per press-release cycle as {row_idx, col_idx}.
module keypad_scanner #(
   parameter int SCAN_DIV     = 100,
   parameter int DEBOUNCE_CNT = 1000
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int CW = $clog2(DEBOUNCE_CNT);
   localparam int DW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_CNT - 1);
   localparam logic [DW-1:0] DIV_TOP = DW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

   state_t          state_q, state_d;
   logic [3:0]      rowMeta_q, rs_q;
   logic [3:0]      col_q, col_d;
   logic [DW-1:0]   div_q, div_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      rowPat_q, rowPat_d;
   logic [3:0]      pend_q, pend_d;
   logic [3:0]      code_q, code_d;
   logic            valid_q, valid_d;
   logic [CW-1:0]   cntInc;
   logic [3:0]      colNext;

   function automatic logic [1:0] oneHotIndex(input logic [3:0] pat);
      case (pat)
         4'b1000: oneHotIndex = 2'd0;
         4'b0100: oneHotIndex = 2'd1;
         4'b0010: oneHotIndex = 2'd2;
         default: oneHotIndex = 2'd3;
      endcase
   endfunction

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         rowMeta_q <= '0;
         rs_q      <= '0;
      end else begin
         rowMeta_q <= row;
         rs_q      <= rowMeta_q;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q  <= SCAN;
         col_q    <= 4'b1000;
         div_q    <= '0;
         cnt_q    <= '0;
         rowPat_q <= '0;
         pend_q   <= '0;
         code_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         rowPat_q <= rowPat_d;
         pend_q   <= pend_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
      end
   end

   assign cntInc  = cnt_q + CW'(1);
   assign colNext = {col_q[0], col_q[3:1]};

   // The counter exits its state on reaching CNT_TOP, so it can never wrap.
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      div_d    = div_q;
      cnt_d    = cnt_q;
      rowPat_d = rowPat_q;
      pend_d   = pend_q;
      code_d   = code_q;
      valid_d  = 1'b0;
      case (state_q)
         SCAN: begin
            if (div_q == DIV_TOP) begin
               div_d = '0;
               if ($onehot(rs_q)) begin
                  rowPat_d = rs_q;
                  pend_d   = {oneHotIndex(rs_q), oneHotIndex(col_q)};
                  cnt_d    = '0;
                  state_d  = DEBOUNCE;
               end else begin
                  col_d = colNext;
               end
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         DEBOUNCE: begin
            if (rs_q == rowPat_q) begin
               cnt_d = cntInc;
               if (cntInc == CNT_TOP) begin
                  state_d = PRESSED;
                  valid_d = 1'b1;
                  code_d  = pend_q;
               end
            end else begin
               state_d = SCAN;
               col_d   = colNext;
               cnt_d   = '0;
               div_d   = '0;
            end
         end
         PRESSED: begin
            if (rs_q == 4'b0000) begin
               state_d = RELEASE;
               cnt_d   = '0;
            end
         end
         default: begin
            if (rs_q == 4'b0000) begin
               cnt_d = cntInc;
               if (cntInc == CNT_TOP) begin
                  state_d = SCAN;
                  col_d   = colNext;
                  div_d   = '0;
                  cnt_d   = '0;
               end
            end else begin
               state_d = PRESSED;
               cnt_d   = '0;
            end
         end
      endcase
   end

   assign col       = col_q;
   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign key_held  = (state_q == PRESSED) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model drives row from col and
// a press/release stimulus; expectations come from timing arithmetic and a code queue.
module tb_keypad_scanner;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 8;

   logic       clk = 1'b0;
   logic       nRst = 1'b0;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic       keyDown = 1'b0;
   logic [1:0] keyR = 2'd0;
   logic [1:0] keyC = 2'd0;
   logic       forceEn = 1'b0;
   logic [3:0] forceVal = 4'b0000;

   int compared = 0;
   int mismatched = 0;
   int frozenViol = 0;
   logic [3:0] heldCol = 4'b0000;
   logic [3:0] gotQ[$];

   keypad_scanner #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) dut (
      .clk       (clk),
      .nRst      (nRst),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // Keypad model: a pressed key connects its row to its column only while that column is driven.
   always_comb begin
      row = 4'b0000;
      if (forceEn)
         row = forceVal;
      else if (keyDown && col[2'd3 - keyC])
         row = 4'b1000 >> keyR;
   end

   always @(negedge clk) begin
      if (key_valid) begin
         gotQ.push_back(key_code);
         heldCol = col;
      end else if (key_held && col !== heldCol) begin
         frozenViol++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic doReset();
      @(negedge clk);
      nRst = 1'b0;
      tick(3);
      nRst = 1'b1;
   endtask

   task automatic waitIdle(output bit idleOk);
      idleOk = 1'b0;
      for (int i = 0; i < 4 * DEBOUNCE_CNT; i++) begin
         @(negedge clk);
         if (!key_held) begin
            idleOk = 1'b1;
            break;
         end
      end
      tick(SCAN_DIV);
   endtask

   task automatic pressKey(input logic [1:0] r, input logic [1:0] c, input int hold, output bit idleOk);
      keyR = r;
      keyC = c;
      keyDown = 1'b1;
      tick(hold);
      keyDown = 1'b0;
      waitIdle(idleOk);
   endtask

   task automatic test_reset();
      keyDown = 1'b0;
      forceEn = 1'b0;
      nRst = 1'b0;
      tick(2);
      compared++;
      if (col !== 4'b1000) begin mismatched++; $display("[TB] FAIL reset_col: got %b want 1000", col); end
      compared++;
      if (key_code !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_code: got %0d want 0", key_code); end
      compared++;
      if (key_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b want 0", key_valid); end
      compared++;
      if (key_held !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_held: got %b want 0", key_held); end
   endtask

   task automatic test_idle_rotation();
      logic [3:0] expCol;
      keyDown = 1'b0;
      doReset();
      for (int k = 0; k < 64; k++) begin
         if (k > 0) @(negedge clk);
         expCol = 4'b1000 >> ((k / SCAN_DIV) % 4);
         compared++;
         if (col !== expCol) begin mismatched++; $display("[TB] FAIL idle_col k=%0d: got %b want %b", k, col, expCol); end
         compared++;
         if (key_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_valid k=%0d: got %b want 0", k, key_valid); end
      end
   endtask

   task automatic test_single_press();
      logic expV;
      logic expH;
      gotQ.delete();
      keyR = 2'd0;
      keyC = 2'd1;
      keyDown = 1'b1;
      doReset();
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         expV = (k == SCAN_DIV * 2 + DEBOUNCE_CNT - 1);
         compared++;
         if (key_valid !== expV) begin mismatched++; $display("[TB] FAIL press_valid k=%0d: got %b want %b", k, key_valid, expV); end
      end
      compared++;
      if (key_code !== 4'd1) begin mismatched++; $display("[TB] FAIL press_code: got %0d want 1", key_code); end
      compared++;
      if (key_held !== 1'b1) begin mismatched++; $display("[TB] FAIL press_held: got %b want 1", key_held); end
      keyDown = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         expH = (j < 2 + DEBOUNCE_CNT);
         compared++;
         if (key_held !== expH) begin mismatched++; $display("[TB] FAIL release_held j=%0d: got %b want %b", j, key_held, expH); end
         if (j == 2 + DEBOUNCE_CNT) begin
            compared++;
            if (col !== 4'b0010) begin mismatched++; $display("[TB] FAIL release_col: got %b want 0010", col); end
         end
      end
      compared++;
      if (gotQ.size() != 1) begin mismatched++; $display("[TB] FAIL press_strobes: got %0d want 1", gotQ.size()); end
      compared++;
      if (frozenViol != 0) begin mismatched++; $display("[TB] FAIL press_frozen: got %0d moves want 0", frozenViol); end
   endtask

   task automatic test_two_keys();
      bit ok;
      int fz0;
      logic [3:0] got;
      gotQ.delete();
      fz0 = frozenViol;
      pressKey(2'd3, 2'd0, 40, ok);
      compared++;
      if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL two_idle1: got %b want 1", ok); end
      pressKey(2'd3, 2'd2, 40, ok);
      compared++;
      if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL two_idle2: got %b want 1", ok); end
      compared++;
      if (gotQ.size() != 2) begin mismatched++; $display("[TB] FAIL two_strobes: got %0d want 2", gotQ.size()); end
      got = (gotQ.size() > 0) ? gotQ.pop_front() : 4'bxxxx;
      compared++;
      if (got !== 4'd12) begin mismatched++; $display("[TB] FAIL two_code1: got %0d want 12", got); end
      got = (gotQ.size() > 0) ? gotQ.pop_front() : 4'bxxxx;
      compared++;
      if (got !== 4'd14) begin mismatched++; $display("[TB] FAIL two_code2: got %0d want 14", got); end
      compared++;
      if (frozenViol != fz0) begin mismatched++; $display("[TB] FAIL two_frozen: got %0d moves want 0", frozenViol - fz0); end
   endtask

   task automatic test_short_press();
      bit found;
      logic [3:0] prev;
      gotQ.delete();
      keyDown = 1'b0;
      found = 1'b0;
      prev = col;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (col == 4'b1000 && prev != 4'b1000) begin
            found = 1'b1;
            break;
         end
         prev = col;
      end
      compared++;
      if (found !== 1'b1) begin mismatched++; $display("[TB] FAIL short_sync: got %b want 1", found); end
      keyR = 2'd2;
      keyC = 2'd0;
      keyDown = 1'b1;
      tick(5);
      keyDown = 1'b0;
      tick(5);
      compared++;
      if (col !== 4'b0100) begin mismatched++; $display("[TB] FAIL short_resume_col: got %b want 0100", col); end
      tick(20);
      compared++;
      if (gotQ.size() != 0) begin mismatched++; $display("[TB] FAIL short_strobes: got %0d want 0", gotQ.size()); end
      compared++;
      if (key_held !== 1'b0) begin mismatched++; $display("[TB] FAIL short_held: got %b want 0", key_held); end
   endtask

   task automatic test_release_glitch();
      bit seen;
      bit ok;
      logic [3:0] got;
      gotQ.delete();
      keyR = 2'd2;
      keyC = 2'd0;
      keyDown = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (key_valid) begin
            seen = 1'b1;
            break;
         end
      end
      compared++;
      if (seen !== 1'b1) begin mismatched++; $display("[TB] FAIL glitch_accept: got %b want 1", seen); end
      tick(5);
      keyDown = 1'b0;
      tick(3);
      keyDown = 1'b1;
      tick(12);
      compared++;
      if (key_held !== 1'b1) begin mismatched++; $display("[TB] FAIL glitch_held: got %b want 1", key_held); end
      compared++;
      if (col !== 4'b1000) begin mismatched++; $display("[TB] FAIL glitch_col: got %b want 1000", col); end
      keyDown = 1'b0;
      waitIdle(ok);
      compared++;
      if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL glitch_idle: got %b want 1", ok); end
      compared++;
      if (gotQ.size() != 1) begin mismatched++; $display("[TB] FAIL glitch_strobes: got %0d want 1", gotQ.size()); end
      got = (gotQ.size() > 0) ? gotQ.pop_front() : 4'bxxxx;
      compared++;
      if (got !== 4'd8) begin mismatched++; $display("[TB] FAIL glitch_code: got %0d want 8", got); end
   endtask

   task automatic test_multi_row();
      logic [3:0] seenMask;
      gotQ.delete();
      forceVal = 4'b1100;
      forceEn = 1'b1;
      seenMask = 4'b0000;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         seenMask = seenMask | col;
      end
      forceEn = 1'b0;
      tick(4);
      compared++;
      if (seenMask !== 4'b1111) begin mismatched++; $display("[TB] FAIL multi_rotation: got %b want 1111", seenMask); end
      compared++;
      if (gotQ.size() != 0) begin mismatched++; $display("[TB] FAIL multi_strobes: got %0d want 0", gotQ.size()); end
      compared++;
      if (key_held !== 1'b0) begin mismatched++; $display("[TB] FAIL multi_held: got %b want 0", key_held); end
   endtask

   task automatic test_reset_mid();
      logic expV;
      bit ok;
      gotQ.delete();
      keyR = 2'd1;
      keyC = 2'd3;
      keyDown = 1'b1;
      doReset();
      tick(18);
      compared++;
      if (col !== 4'b0001) begin mismatched++; $display("[TB] FAIL rmid_freeze_col: got %b want 0001", col); end
      compared++;
      if (gotQ.size() != 0) begin mismatched++; $display("[TB] FAIL rmid_early: got %0d want 0", gotQ.size()); end
      nRst = 1'b0;
      #1;
      compared++;
      if (col !== 4'b1000) begin mismatched++; $display("[TB] FAIL rmid_deb_col: got %b want 1000", col); end
      compared++;
      if (key_valid !== 1'b0 || key_held !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_deb_flags: got %b%b want 00", key_valid, key_held); end
      for (int pass = 0; pass < 2; pass++) begin
         tick(2);
         nRst = 1'b1;
         for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            expV = (k == SCAN_DIV * 4 + DEBOUNCE_CNT - 1);
            compared++;
            if (key_valid !== expV) begin mismatched++; $display("[TB] FAIL rmid_valid p=%0d k=%0d: got %b want %b", pass, k, key_valid, expV); end
         end
         compared++;
         if (key_code !== 4'd7) begin mismatched++; $display("[TB] FAIL rmid_code p=%0d: got %0d want 7", pass, key_code); end
         if (pass == 0) begin
            nRst = 1'b0;
            #1;
            compared++;
            if (key_held !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_prs_held: got %b want 0", key_held); end
            compared++;
            if (key_code !== 4'd0) begin mismatched++; $display("[TB] FAIL rmid_prs_code: got %0d want 0", key_code); end
            compared++;
            if (col !== 4'b1000) begin mismatched++; $display("[TB] FAIL rmid_prs_col: got %b want 1000", col); end
         end
      end
      compared++;
      if (gotQ.size() != 2) begin mismatched++; $display("[TB] FAIL rmid_strobes: got %0d want 2", gotQ.size()); end
      keyDown = 1'b0;
      waitIdle(ok);
      compared++;
      if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL rmid_idle: got %b want 1", ok); end
   endtask

   task automatic test_random();
      logic [1:0] r;
      logic [1:0] c;
      int hold;
      int glitch;
      bit ok;
      logic [3:0] expCode;
      logic [3:0] got;
      for (int it = 0; it < 8; it++) begin
         gotQ.delete();
         r = 2'($urandom_range(0, 3));
         c = 2'($urandom_range(0, 3));
         hold = $urandom_range(5, 20);
         glitch = $urandom_range(1, 3);
         expCode = 4'(r * 4 + c);
         keyR = r;
         keyC = c;
         keyDown = 1'b1;
         tick(40);
         keyDown = 1'b0;
         tick(glitch);
         keyDown = 1'b1;
         tick(hold);
         keyDown = 1'b0;
         waitIdle(ok);
         compared++;
         if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL rand_idle it=%0d: got %b want 1", it, ok); end
         compared++;
         if (gotQ.size() != 1) begin mismatched++; $display("[TB] FAIL rand_strobes it=%0d: got %0d want 1", it, gotQ.size()); end
         got = (gotQ.size() > 0) ? gotQ.pop_front() : 4'bxxxx;
         compared++;
         if (got !== expCode) begin mismatched++; $display("[TB] FAIL rand_code it=%0d: got %0d want %0d", it, got, expCode); end
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_idle_rotation();
      test_single_press();
      test_two_keys();
      test_short_press();
      test_release_glitch();
      test_multi_row();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001: Parameter SCAN_DIV, default 100: clock cycles per column dwell; legal range is at least 2.
REQ-002: Parameter DEBOUNCE_CNT, default 1000: consecutive stable synchronized cycles needed to accept a press or a release; legal range is at least 2.
REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004: nRst  input  1  asynchronous, active-low reset.
REQ-005: row  input  4  raw keypad row sense; row[3]=R0, row[2]=R1, row[1]=R2, row[0]=R3; asynchronous to clk.
REQ-006: col  output  4  one-hot column drive; col[3]=C0, col[2]=C1, col[1]=C2, col[0]=C3.
REQ-007: key_code  output  4  accepted key, encoded as {row_idx[1:0], col_idx[1:0]} (R0C1=4'd1, R3C0=4'd12, R3C2=4'd14).
REQ-008: key_valid  output  1  one-cycle strobe; key_code is valid in that cycle.
REQ-009: key_held  output  1  high while an accepted key remains pressed (PRESSED or RELEASE state).

Function
REQ-010: row SHALL pass through a 2-flop synchronizer (reset to 0); all decisions below use the synchronized value rs.
REQ-011: States SHALL be SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-012: SCAN SHALL rotate col C0->C1->C2->C3->C0 (4'b1000->0100->0010->0001->1000) after every SCAN_DIV cycles of dwell.
REQ-013: SCAN SHALL sample rs only in the final dwell cycle of a column, so that col has settled.
REQ-014: In SCAN, if the sample is one-hot: latch row_idx and col_idx, freeze col, clear the counter and go to DEBOUNCE.
REQ-015: In SCAN, if the sample is zero or has more than one bit set: continue rotating and emit nothing.
REQ-016: DEBOUNCE SHALL increment the counter each cycle that rs equals the latched row pattern.
REQ-017: In DEBOUNCE, any mismatch SHALL return to SCAN, resume rotation from the next column, clear the counter and emit no strobe.
REQ-018: When the counter reaches DEBOUNCE_CNT-1, the block SHALL go to PRESSED, pulse key_valid for exactly one cycle and update key_code in that same cycle.
REQ-019: key_code SHALL hold its value until the next accepted key.
REQ-020: Latency is fixed: key_valid asserts DEBOUNCE_CNT cycles after the SCAN sample cycle, with stable input.
REQ-021: PRESSED SHALL keep col frozen, ignore every non-zero rs and issue no auto-repeat; rs==0 goes to RELEASE with the counter cleared.
REQ-022: RELEASE SHALL count cycles with rs==0; any non-zero rs returns to PRESSED with no new strobe.
REQ-023: When the RELEASE counter reaches DEBOUNCE_CNT-1, the block SHALL go to SCAN and advance col to the next column.
REQ-024: The counter SHALL be sized by $clog2(DEBOUNCE_CNT) and SHALL never wrap; it saturates by state exit.
REQ-025: At most one key_valid SHALL occur per physical press-release cycle, including when bounces occur in any state.

Reset
REQ-026: With nRst=0, state=SCAN, col=4'b1000, key_code=4'd0, key_valid=0, key_held=0, counters=0 and synchronizer=0, all immediately and asynchronously.
REQ-027: Reset asserted mid-press SHALL discard the press; after release of nRst, a still-held key is re-detected through the full SCAN/DEBOUNCE path (one new strobe).
REQ-028: The first SCAN sample after reset SHALL occur SCAN_DIV cycles after nRst deasserts.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-029: Reset, then row=0 for 64 cycles -> col cycles 1000,0100,0010,0001 at 4 cycles each; key_valid never high.
REQ-030: Hold row=4'b1000 only while col=0100 (keypad model) for 40 cycles -> exactly one key_valid, key_code=4'd1; key_held high until 8 cycles after release.
REQ-031: Press R3C0 (row=0001 when col=1000), release, then press R3C2 -> two strobes with key_code=12 then 14; col frozen during each hold.
REQ-032: Press R2C0 for 5 cycles only -> return to SCAN, no strobe; a 3-cycle release glitch during a held R2C0 press -> still a single strobe (key_code=8).
REQ-033: row=4'b1100 during any column -> no strobe, rotation continues.
REQ-034: Pull nRst low during DEBOUNCE and while PRESSED -> outputs at reset values in the same cycle; a held key yields one fresh strobe after reset.
